// File: rtl/gate_bist_sequencer.sv
// BIST sequencer for the two-input gate bank: sweeps {a,b} through 00..11,
// samples gate_out after a settle window and logs mismatches against a local model.
module gate_bist_sequencer #(
  parameter int SETTLE = 0,
  parameter int LOOPS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [7:0] gate_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [1:0] fail_vec,
  output logic [7:0] fail_mask
);

  localparam logic [3:0] SETTLE_L   = 4'(SETTLE);
  localparam logic [7:0] LAST_SWEEP = 8'(LOOPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t     state, state_nxt;
  logic [1:0] vec, vec_nxt;
  logic [3:0] settle_cnt, settle_nxt;
  logic [7:0] sweep_cnt, sweep_nxt;
  logic       busy_nxt, done_nxt, pass_nxt;
  logic [7:0] err_nxt, mask_nxt;
  logic [1:0] fvec_nxt;

  logic [7:0] expected;
  logic [7:0] diff;
  logic       mism;
  logic       sample;
  logic       last;

  assign a = vec[1];
  assign b = vec[0];

  // Bit order: {xnor, xor, nor, nand, not_b, not_a, or, and}
  assign expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~b, ~a, a | b, a & b};
  assign diff     = expected ^ gate_out;
  assign mism     = |diff;
  assign sample   = (state == RUN) && (settle_cnt == SETTLE_L);
  assign last     = sample && (vec == 2'b11) && (sweep_cnt == LAST_SWEEP);

  always_comb begin
    state_nxt  = state;
    vec_nxt    = vec;
    settle_nxt = settle_cnt;
    sweep_nxt  = sweep_cnt;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    pass_nxt   = pass;
    err_nxt    = err_count;
    fvec_nxt   = fail_vec;
    mask_nxt   = fail_mask;

    case (state)
      IDLE, FIN: begin
        if (state == FIN) state_nxt = IDLE;
        if (start) begin
          state_nxt  = RUN;
          busy_nxt   = 1'b1;
          vec_nxt    = 2'b00;
          settle_nxt = '0;
          sweep_nxt  = '0;
          err_nxt    = '0;
          pass_nxt   = 1'b0;
          fvec_nxt   = '0;
          mask_nxt   = '0;
        end
      end
      RUN: begin
        if (sample) begin
          settle_nxt = '0;
          if (mism) begin
            if (err_count != 8'hFF) err_nxt = err_count + 8'd1;
            // err_count never returns to zero once bumped, so zero marks "no mismatch yet"
            if (err_count == 8'h00) begin
              fvec_nxt = vec;
              mask_nxt = diff;
            end
          end
          vec_nxt = vec + 2'd1;
          if (vec == 2'b11) sweep_nxt = sweep_cnt + 8'd1;
          if (last) begin
            state_nxt = FIN;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            vec_nxt   = 2'b00;
            pass_nxt  = (err_nxt == 8'h00);
          end
        end else begin
          settle_nxt = settle_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      sweep_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_mask  <= '0;
    end else begin
      state      <= state_nxt;
      vec        <= vec_nxt;
      settle_cnt <= settle_nxt;
      sweep_cnt  <= sweep_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_count  <= err_nxt;
      fail_vec   <= fvec_nxt;
      fail_mask  <= mask_nxt;
    end
  end

endmodule

// File: tb/tb_gate_bist_sequencer.sv
// Scoreboard bench: three sequencer instances (defaults, SETTLE=2/LOOPS=3, LOOPS=100)
// each driving a behavioural gate bank with injectable faults.
module tb_gate_bist_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic       fault0 = 1'b0, zero2 = 1'b0;
  logic       a0, b0, a1, b1, a2, b2;
  logic [2:0] busy_w, done_w, pass_w;
  logic [7:0] go0, go1, go2, err0, err1, err2, fm0, fm1, fm2;
  logic [1:0] fv0, fv1, fv2;

  function automatic logic [7:0] gold(input logic x, input logic y);
    return {~(x ^ y), x ^ y, ~(x | y), ~(x & y), ~y, ~x, x | y, x & y};
  endfunction

  // u1's bank always has xor stuck at 0
  assign go0 = gold(a0, b0) & ~(fault0 ? 8'h40 : 8'h00);
  assign go1 = gold(a1, b1) & 8'hBF;
  assign go2 = zero2 ? 8'h00 : gold(a2, b2);

  gate_bist_sequencer #(.SETTLE(0), .LOOPS(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .gate_out(go0),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err0), .fail_vec(fv0), .fail_mask(fm0));
  gate_bist_sequencer #(.SETTLE(2), .LOOPS(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .gate_out(go1),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err1), .fail_vec(fv1), .fail_mask(fm1));
  gate_bist_sequencer #(.SETTLE(0), .LOOPS(100)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .gate_out(go2),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .err_count(err2), .fail_vec(fv2), .fail_mask(fm2));

  typedef struct {
    int         inst;
    logic [7:0] err;
    logic       pass;
    logic [1:0] fv;
    logic [7:0] fm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int i, input logic v);
    case (i)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Returns with edge 0 just taken.
  task automatic pulse_start(input int i);
    set_start(i, 1'b1);
    tick();
    set_start(i, 1'b0);
  endtask

  task automatic wait_done(input int i, input int budget, output int n);
    n = 0;
    while (!done_w[i] && n < budget) begin
      tick();
      n++;
    end
    if (!done_w[i]) begin
      checks++;
      $display("FAIL done_timeout inst %0d: got no done within %0d cycles", i, budget);
    end
  endtask

  // Monitor: every done pulse pops and checks one scoreboard entry.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_w[i] && !rst) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done on inst %0d, expected none", i);
        end else begin
          exp_t e;
          logic [7:0] ge, gm;
          logic [1:0] gv;
          e = sb.pop_front();
          case (i)
            0: begin ge = err0; gv = fv0; gm = fm0; end
            1: begin ge = err1; gv = fv1; gm = fm1; end
            default: begin ge = err2; gv = fv2; gm = fm2; end
          endcase
          chk("sb_inst", i, e.inst);
          chk("sb_err_count", ge, e.err);
          chk("sb_pass", pass_w[i], e.pass);
          chk("sb_fail_vec", gv, e.fv);
          chk("sb_fail_mask", gm, e.fm);
          chk("sb_busy_low", busy_w[i], 0);
        end
      end
    end
  end

  initial begin
    int n;
    tick();
    tick();
    chk("rst_ab", {a0, b0}, 0);
    chk("rst_busy", busy_w, 0);
    chk("rst_done", done_w, 0);
    chk("rst_pass", pass_w, 0);
    chk("rst_err", err0, 0);
    chk("rst_fail_vec", fv0, 0);
    chk("rst_fail_mask", fm0, 0);
    rst = 1'b0;
    tick();

    // Clean bank, defaults: vector sequence and done timing
    sb.push_back('{0, 8'd0, 1'b1, 2'b00, 8'h00});
    pulse_start(0);
    chk("t1_ab_e0", {a0, b0}, 0);
    chk("t1_busy_e0", busy_w[0], 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("t1_ab_seq", {a0, b0}, k);
      chk("t1_no_done", done_w[0], 0);
    end
    tick();
    chk("t1_done_e4", done_w[0], 1);
    chk("t1_busy_e4", busy_w[0], 0);
    chk("t1_ab_home", {a0, b0}, 0);
    chk("t1_pass", pass_w[0], 1);
    tick();
    chk("t1_done_one_cycle", done_w[0], 0);

    // xor stuck at 0, defaults
    fault0 = 1'b1;
    sb.push_back('{0, 8'd2, 1'b0, 2'b01, 8'h40});
    pulse_start(0);
    wait_done(0, 20, n);
    chk("t2_latency", n, 4);
    tick();

    // Same fault, SETTLE=2 LOOPS=3: each vector held 3 cycles, done after edge 36
    sb.push_back('{1, 8'd6, 1'b0, 2'b01, 8'h40});
    pulse_start(1);
    for (int e = 1; e < 36; e++) begin
      tick();
      chk("t3_ab_hold", {a1, b1}, (e / 3) % 4);
      chk("t3_no_done", done_w[1], 0);
    end
    tick();
    chk("t3_done_e36", done_w[1], 1);
    chk("t3_ab_home", {a1, b1}, 0);
    tick();

    // start during RUN ignored; start during FIN restarts with cleared results
    sb.push_back('{0, 8'd2, 1'b0, 2'b01, 8'h40});
    pulse_start(0);
    start0 = 1'b1;
    tick();
    tick();
    start0 = 1'b0;
    tick();
    chk("t4_run_busy", busy_w[0], 1);
    tick();
    chk("t4_done_unmoved", done_w[0], 1);
    start0 = 1'b1;
    fault0 = 1'b0;
    sb.push_back('{0, 8'd0, 1'b1, 2'b00, 8'h00});
    tick();
    start0 = 1'b0;
    chk("t4_restart_busy", busy_w[0], 1);
    chk("t4_restart_done", done_w[0], 0);
    chk("t4_restart_err", err0, 0);
    chk("t4_restart_pass", pass_w[0], 0);
    chk("t4_restart_mask", fm0, 0);
    chk("t4_restart_ab", {a0, b0}, 0);
    wait_done(0, 10, n);
    chk("t4_latency", n, 4);
    tick();

    // rst mid-sweep after one mismatch logged
    fault0 = 1'b1;
    pulse_start(0);
    tick();
    tick();
    chk("t5_err_before_rst", err0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", busy_w[0], 0);
    chk("t5_ab", {a0, b0}, 0);
    chk("t5_err", err0, 0);
    chk("t5_mask", fm0, 0);
    chk("t5_done", done_w[0], 0);
    repeat (8) tick();
    fault0 = 1'b0;
    sb.push_back('{0, 8'd0, 1'b1, 2'b00, 8'h00});
    pulse_start(0);
    wait_done(0, 10, n);
    chk("t5_clean_latency", n, 4);
    tick();

    // All-zero bank over 100 sweeps: err_count saturates
    zero2 = 1'b1;
    sb.push_back('{2, 8'd255, 1'b0, 2'b00, 8'hBC});
    pulse_start(2);
    wait_done(2, 500, n);
    chk("t6_latency", n, 400);
    tick();
    tick();

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gate_bist_sequencer.md
# gate_bist_sequencer

Built-in self-test sequencer for the two-input logic gate bank. On a start pulse it drives the `a` and `b` inputs of the gate bank through all four input combinations. After a settle window it samples the bank's eight gate outputs and compares them against internally computed expected values. It accumulates a mismatch count and reports pass/fail, so it sits both upstream of the gate bank (stimulus) and downstream of it (checking).

## Interface
- `SETTLE` — default 0 — extra cycles each vector is held before `gate_out` is sampled (range 0–15).
- `LOOPS` — default 1 — number of full four-vector sweeps per start (range 1–255).

Ports:
- `clk` — in — 1 — single clock; all logic is rising-edge.
- `rst` — in — 1 — synchronous, active-high reset.
- `start` — in — 1 — begin a self-test; sampled only while idle.
- `a` — out — 1 — registered stimulus to the gate bank.
- `b` — out — 1 — registered stimulus to the gate bank.
- `gate_out` — in — 8 — gate bank outputs, packed as follows:
  - bit0 `and`, bit1 `or`, bit2 `not_a`, bit3 `not_b`
  - bit4 `nand`, bit5 `nor`, bit6 `xor`, bit7 `xnor`
- `busy` — out — 1 — high while a sweep is in progress.
- `done` — out — 1 — one-cycle pulse when the test completes.
- `pass` — out — 1 — high when the last test had zero mismatches; valid from `done` onward.
- `err_count` — out — 8 — number of mismatching vectors, saturating at 255.
- `fail_vec` — out — 2 — `{a,b}` of the first mismatching vector.
- `fail_mask` — out — 8 — `expected ^ gate_out` captured at the first mismatch.

## Operation
- States: IDLE, RUN, FIN.
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, `fail_mask`=0; state IDLE.
- IDLE, on `start`=1:
  - Go to RUN.
  - `busy`=1; `{a,b}`=00; sweep and settle counters cleared.
  - Clear `err_count`, `pass`, `fail_vec`, `fail_mask`.
- RUN:
  - Vector order per sweep is `{a,b}` = 00, 01, 10, 11 (`a` is MSB).
  - Each vector is held `SETTLE`+1 cycles and sampled on the last edge of that window.
- Expected value, computed from the registered `a` and `b`: `{~(a^b), a^b, ~(a|b), ~(a&b), ~b, ~a, a|b, a&b}`.
- On each sample edge:
  - If expected ≠ `gate_out`, increment `err_count` (saturating at 255).
  - If this is the first mismatch since start, capture `fail_vec`={a,b} and `fail_mask`.
  - On the same edge, advance to the next vector. After 11, wrap to 00 and increment the sweep count.
- After the final sample of sweep `LOOPS`:
  - Go to FIN.
  - `busy`=0; `done`=1; `pass`=(final `err_count`==0); `{a,b}` returns to 00.
- FIN lasts one cycle, then returns to IDLE with `done`=0.
  - `start` during FIN is accepted: it goes directly to RUN with results cleared, `done` deasserts, `busy`=1.
- `start` during RUN is ignored.
- Results hold until the next accepted start or `rst`.
- `rst` mid-sweep forces all reset values on that edge, with no `done` pulse.

## Timing
- Edge numbering: edge 0 is the edge that samples `start`=1 in IDLE.
- Vector k (k=0..4·`LOOPS`−1):
  - Driven on `a`/`b` starting at edge k·(`SETTLE`+1).
  - Sampled at edge (k+1)·(`SETTLE`+1).
- `busy` rises after edge 0.
- `done` is high for the single cycle after edge 4·`LOOPS`·(`SETTLE`+1).
- Latency from start to `done`, with defaults: 4 cycles plus 1 (`done` is visible in cycle 5).
- `gate_out` is treated as combinational from `a`/`b`. With `SETTLE`=0 it must be valid within one cycle.
- `err_count` and first-fail fields update on the sample edge itself, so they are visible the following cycle.

## Test plan
- Reset, connect a correct gate bank, defaults, pulse `start`.
  - Required: `{a,b}` = 00, 01, 10, 11 after edges 0–3.
  - Required: `done` pulses in cycle 5; `pass`=1, `err_count`=0, `busy`=0.
- `xor` bit stuck at 0 (`gate_out[6]`=0), defaults.
  - Required: `err_count`=2, `pass`=0, `fail_vec`=01, `fail_mask`=8'h40.
- Same fault with `LOOPS`=3, `SETTLE`=2.
  - Required: `err_count`=6.
  - Required: `done` in the cycle after edge 36; each vector is stable for exactly 3 cycles.
- `start` pulsed during RUN has no effect. `start` asserted in the FIN cycle:
  - Required: a new sweep begins with `err_count`=0 and `pass`=0, and `busy`=1 the next cycle.
- `rst` asserted after edge 2 of a sweep with one mismatch already logged.
  - Required next cycle: `busy`=0, `a`=`b`=0, `err_count`=0, `fail_mask`=0, and no `done` pulse.
  - Required: a later `start` runs a full clean sweep.
- `gate_out` forced to 8'h00, `LOOPS`=100.
  - Every vector mismatches; `err_count` saturates at 255 (not wrapping to 144).
  - Required: `fail_vec`=00, `fail_mask`=8'hBC, `pass`=0.
